alu_op_sequencer: RTL and testbench

Control-side counterpart of the 16-bit ALU. Accepts encoded instructions over a valid/ready handshake, decodes them, and reads operands from a 4-entry internal register file. It drives the ALU's A/B/select inputs, captures the ALU output, writes the result back, and returns it over a valid/ready result port. The ALU itself is external; this block sits between the instruction source and the ALU.

---
 rtl/alu_seq_pkg.sv | 33 +++
 rtl/alu_seq_regfile.sv | 33 +++
 rtl/alu_op_sequencer.sv | 117 +++++++++++
 tb/tb_alu_op_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and instruction field positions for alu_op_sequencer
package alu_seq_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_NOT = 3'b100,
      OP_CLR = 3'b101,
      OP_MOV = 3'b110,
      OP_LDI = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int OP_MSB   = 15;
   localparam int OP_LSB   = 13;
   localparam int RD_MSB   = 12;
   localparam int RD_LSB   = 11;
   localparam int RA_MSB   = 10;
   localparam int RA_LSB   = 9;
   localparam int RB_MSB   = 8;
   localparam int RB_LSB   = 7;
   localparam int IMM_MSB  = 8;
   localparam int IMM_LSB  = 0;
   localparam int NUM_REGS = 4;

endpackage

// File: rtl/alu_seq_regfile.sv
// rtl/alu_seq_regfile.sv - 4-entry register file, two async reads, one sync write, async clear
module alu_seq_regfile
   import alu_seq_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [1:0]        waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [1:0]        raddr_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic [1:0]        raddr_b,
   output logic [DATA_W-1:0] rdata_b
);

   logic [DATA_W-1:0] regs [NUM_REGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata_a = regs[raddr_a];
   assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - decodes instructions, drives the external ALU, writes back and returns results
// Optional flag outputs flag_z/flag_n are built when ALU_SEQ_FLAGS_EN is defined.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       in_instr,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_sel,
   input  logic [DATA_W-1:0] alu_result,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
`ifdef ALU_SEQ_FLAGS_EN
   output logic              flag_z,
   output logic              flag_n,
`endif
   output logic [1:0]        res_rd
);

   state_e            state;
   op_e               op_q;
   logic [1:0]        rd_q;
   logic [8:0]        imm_q;
   logic [DATA_W-1:0] rdata_a;
   logic [DATA_W-1:0] rdata_b;
   logic [DATA_W-1:0] wb_value;
   logic              wb_en;

   // Read ports are addressed straight from the instruction so operands snapshot at accept.
   alu_seq_regfile #(.DATA_W(DATA_W)) u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (wb_en),
      .waddr   (rd_q),
      .wdata   (wb_value),
      .raddr_a (in_instr[RA_MSB:RA_LSB]),
      .rdata_a (rdata_a),
      .raddr_b (in_instr[RB_MSB:RB_LSB]),
      .rdata_b (rdata_b)
   );

   assign wb_en = (state == EXEC);

   always_comb begin
      wb_value = '0;
      if (op_q == OP_LDI) begin
         wb_value[8:0] = imm_q;
      end else begin
         wb_value = alu_result;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         res_valid <= 1'b0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_sel   <= 3'b000;
         res_data  <= '0;
         res_rd    <= 2'd0;
         op_q      <= OP_ADD;
         rd_q      <= 2'd0;
         imm_q     <= 9'd0;
`ifdef ALU_SEQ_FLAGS_EN
         flag_z    <= 1'b0;
         flag_n    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  alu_sel  <= in_instr[OP_MSB:OP_LSB];
                  alu_a    <= rdata_a;
                  alu_b    <= rdata_b;
                  op_q     <= op_e'(in_instr[OP_MSB:OP_LSB]);
                  rd_q     <= in_instr[RD_MSB:RD_LSB];
                  imm_q    <= in_instr[IMM_MSB:IMM_LSB];
                  in_ready <= 1'b0;
                  state    <= EXEC;
               end
            end
            EXEC: begin
               res_data  <= wb_value;
               res_rd    <= rd_q;
               res_valid <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
               flag_z    <= (wb_value == '0);
               flag_n    <= wb_value[DATA_W-1];
`endif
               state     <= RESP;
            end
            RESP: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed table-driven bench for alu_op_sequencer with a behavioural ALU
module tb_alu_op_sequencer;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_instr;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [2:0]  alu_sel;
   logic [15:0] alu_result;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_data;
   logic [1:0]  res_rd;
`ifdef ALU_SEQ_FLAGS_EN
   logic        flag_z;
   logic        flag_n;
`endif

   int checks = 0;
   int errors = 0;

   alu_op_sequencer #(.DATA_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_sel    (alu_sel),
      .alu_result (alu_result),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
`ifdef ALU_SEQ_FLAGS_EN
      .flag_z     (flag_z),
      .flag_n     (flag_n),
`endif
      .res_rd     (res_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      case (alu_sel)
         3'b000:  alu_result = alu_a + alu_b;
         3'b001:  alu_result = alu_a - alu_b;
         3'b010:  alu_result = alu_a & alu_b;
         3'b011:  alu_result = alu_a | alu_b;
         3'b100:  alu_result = ~alu_a;
         3'b101:  alu_result = 16'h0000;
         3'b110:  alu_result = alu_a;
         default: alu_result = 16'hDEAD;
      endcase
   end

   typedef struct {
      logic [15:0] instr;
      logic [15:0] exp_data;
      logic [1:0]  exp_rd;
   } vec_t;

   vec_t vecs [15];

   function automatic logic [15:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] ra, input logic [1:0] rb);
      return {op, rd, ra, rb, 7'b0};
   endfunction

   function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [8:0] imm);
      return {3'b111, rd, 2'b00, imm};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
   endtask

   // Full handshake with res_ready held high: accept, EXEC, RESP, back to IDLE.
   task automatic do_op(input logic [15:0] instr, input logic [15:0] exp, input logic [1:0] exp_rd);
      wait_ready();
      in_valid  = 1'b1;
      in_instr  = instr;
      res_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("exec_in_ready", {31'b0, in_ready}, 32'd0);
      chk("exec_res_valid", {31'b0, res_valid}, 32'd0);
      if (instr[15:13] != 3'b111)
         chk("exec_alu_sel", {29'b0, alu_sel}, {29'b0, instr[15:13]});
      @(posedge clk); #1;
      chk("resp_valid", {31'b0, res_valid}, 32'd1);
      chk("resp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("resp_data", {16'b0, res_data}, {16'b0, exp});
      chk("resp_rd", {30'b0, res_rd}, {30'b0, exp_rd});
      @(posedge clk); #1;
      chk("idle_res_valid", {31'b0, res_valid}, 32'd0);
      chk("idle_in_ready", {31'b0, in_ready}, 32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = 16'h0000;
      res_ready = 1'b0;

      vecs[0]  = '{ldi(2'd1, 9'd5),                 16'h0005, 2'd1};
      vecs[1]  = '{ldi(2'd2, 9'd3),                 16'h0003, 2'd2};
      vecs[2]  = '{enc(3'b000, 2'd0, 2'd1, 2'd2),   16'h0008, 2'd0};
      vecs[3]  = '{enc(3'b001, 2'd3, 2'd0, 2'd0),   16'h0000, 2'd3};
      vecs[4]  = '{enc(3'b001, 2'd3, 2'd3, 2'd1),   16'hFFFB, 2'd3};
      vecs[5]  = '{ldi(2'd1, 9'h0F0),               16'h00F0, 2'd1};
      vecs[6]  = '{ldi(2'd2, 9'h0FF),               16'h00FF, 2'd2};
      vecs[7]  = '{enc(3'b010, 2'd0, 2'd1, 2'd2),   16'h00F0, 2'd0};
      vecs[8]  = '{enc(3'b011, 2'd0, 2'd1, 2'd2),   16'h00FF, 2'd0};
      vecs[9]  = '{enc(3'b100, 2'd0, 2'd1, 2'd0),   16'hFF0F, 2'd0};
      vecs[10] = '{enc(3'b101, 2'd0, 2'd1, 2'd2),   16'h0000, 2'd0};
      vecs[11] = '{enc(3'b110, 2'd3, 2'd1, 2'd0),   16'h00F0, 2'd3};
      vecs[12] = '{ldi(2'd0, 9'h1FF),               16'h01FF, 2'd0};
      vecs[13] = '{enc(3'b000, 2'd1, 2'd1, 2'd1),   16'h01E0, 2'd1};
      vecs[14] = '{enc(3'b000, 2'd2, 2'd0, 2'd3),   16'h02EF, 2'd2};

      #12;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
      chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
      chk("rst_alu_a", {16'b0, alu_a}, 32'd0);
      chk("rst_alu_b", {16'b0, alu_b}, 32'd0);
      chk("rst_alu_sel", {29'b0, alu_sel}, 32'd0);
      chk("rst_res_data", {16'b0, res_data}, 32'd0);
      chk("rst_res_rd", {30'b0, res_rd}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

      for (int i = 0; i < 15; i++) begin
         do_op(vecs[i].instr, vecs[i].exp_data, vecs[i].exp_rd);
      end

      // Backpressure: result held while res_ready low, pending instruction waits.
      wait_ready();
      in_valid  = 1'b1;
      in_instr  = ldi(2'd0, 9'd7);
      res_ready = 1'b0;
      @(posedge clk); #1;
      in_instr = enc(3'b000, 2'd1, 2'd0, 2'd0);
      @(posedge clk); #1;
      for (int c = 0; c < 5; c++) begin
         chk("bp_res_valid", {31'b0, res_valid}, 32'd1);
         chk("bp_res_data", {16'b0, res_data}, 32'h0007);
         chk("bp_res_rd", {30'b0, res_rd}, 32'd0);
         chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
         @(posedge clk); #1;
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_valid", {31'b0, res_valid}, 32'd0);
      chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_accept", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
      chk("bp_second_valid", {31'b0, res_valid}, 32'd1);
      chk("bp_second_data", {16'b0, res_data}, 32'h000E);
      chk("bp_second_rd", {30'b0, res_rd}, 32'd1);
      @(posedge clk); #1;

      // Reset during EXEC of ADD r0=r0+r0 (r0 holds 7).
      wait_ready();
      in_valid = 1'b1;
      in_instr = enc(3'b000, 2'd0, 2'd0, 2'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("midrst_res_valid", {31'b0, res_valid}, 32'd0);
      chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("midrst_hold_valid", {31'b0, res_valid}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midrst_in_ready_after", {31'b0, in_ready}, 32'd1);
      do_op(enc(3'b110, 2'd1, 2'd0, 2'd0), 16'h0000, 2'd1);
      do_op(enc(3'b110, 2'd0, 2'd2, 2'd0), 16'h0000, 2'd0);
      do_op(enc(3'b011, 2'd0, 2'd3, 2'd1), 16'h0000, 2'd0);

`ifdef ALU_SEQ_FLAGS_EN
      do_op(enc(3'b001, 2'd0, 2'd1, 2'd1), 16'h0000, 2'd0);
      chk("flag_z_set", {31'b0, flag_z}, 32'd1);
      chk("flag_n_clr", {31'b0, flag_n}, 32'd0);
      do_op(ldi(2'd2, 9'd1), 16'h0001, 2'd2);
      do_op(enc(3'b001, 2'd0, 2'd0, 2'd2), 16'hFFFF, 2'd0);
      chk("flag_z_clr", {31'b0, flag_z}, 32'd0);
      chk("flag_n_set", {31'b0, flag_n}, 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
